// File: rtl/timer_reg_master.sv
// timer_reg_master: command-driven initiator for the timer's 8-bit register
// bus. Turns write / read / read-modify-write / poll commands into one-clock
// register-bus cycles and returns exactly one response per command.
module timer_reg_master #(
  parameter int unsigned POLL_MAX = 16  // max read attempts for a poll (1..255)
) (
  input  logic       clk,
  input  logic       rst,
  // host command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_mask,
  // host response channel
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  // register bus
  output logic       module_en,
  output logic       wr,
  output logic [5:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RMW_RD, RMW_WR, POLL_RD, POLL_GAP, RESP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

  state_t     state, state_d;
  logic [5:0] addr_q, addr_q_d;
  logic [7:0] data_q, data_q_d;
  logic [7:0] mask_q, mask_q_d;
  logic [7:0] attempts, attempts_d;
  logic [7:0] rsp_data_d;
  logic       rsp_err_d;
  logic       module_en_d, wr_d;
  logic [5:0] addr_d;
  logic [7:0] wdata_d;
  logic [7:0] merged;
  logic [7:0] attempts_inc;
  logic       poll_match;

  // Handshake outputs decode the state; ready is forced low while in reset.
  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

  assign merged       = (rdata & ~mask_q) | (data_q & mask_q);
  assign attempts_inc = attempts + 8'd1;
  assign poll_match   = ((rdata ^ data_q) & mask_q) == 8'h00;

  // Next-state, next bus cycle and next response value.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch. The bus defaults to
    // idle (all zero), so only states that start a cycle need to drive it.
    state_d     = state;
    addr_q_d    = addr_q;
    data_q_d    = data_q;
    mask_q_d    = mask_q;
    attempts_d  = attempts;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    module_en_d = 1'b0;
    wr_d        = 1'b0;
    addr_d      = 6'd0;
    wdata_d     = 8'd0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_q_d    = cmd_addr;
          data_q_d    = cmd_data;
          mask_q_d    = cmd_mask;
          attempts_d  = 8'd0;
          module_en_d = 1'b1;
          addr_d      = cmd_addr;
          case (cmd_op)
            OP_WRITE: begin
              state_d = WR;
              wr_d    = 1'b1;
              wdata_d = cmd_data;
            end
            OP_READ: state_d = RD;
            OP_RMW:  state_d = RMW_RD;
            default: state_d = POLL_RD;
          endcase
        end
      end

      WR: begin
        rsp_data_d = data_q;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end

      RD: begin
        rsp_data_d = rdata;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end

      // Read value is merged and the write cycle follows with no idle gap.
      RMW_RD: begin
        module_en_d = 1'b1;
        wr_d        = 1'b1;
        addr_d      = addr_q;
        wdata_d     = merged;
        state_d     = RMW_WR;
      end

      RMW_WR: begin
        rsp_data_d = wdata;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end

      POLL_RD: begin
        attempts_d = attempts_inc;
        if (poll_match) begin
          rsp_data_d = rdata;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (attempts_inc == POLL_LIMIT) begin
          rsp_data_d = rdata;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          state_d = POLL_GAP;
        end
      end

      // One idle bus cycle, then the next poll read is launched.
      POLL_GAP: begin
        module_en_d = 1'b1;
        addr_d      = addr_q;
        state_d     = POLL_RD;
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, command latches, response and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 6'd0;
      data_q    <= 8'd0;
      mask_q    <= 8'd0;
      attempts  <= 8'd0;
      rsp_data  <= 8'd0;
      rsp_err   <= 1'b0;
      module_en <= 1'b0;
      wr        <= 1'b0;
      addr      <= 6'd0;
      wdata     <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from
      // pre-edge values, independent of statement order.
      state     <= state_d;
      addr_q    <= addr_q_d;
      data_q    <= data_q_d;
      mask_q    <= mask_q_d;
      attempts  <= attempts_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      module_en <= module_en_d;
      wr        <= wr_d;
      addr      <= addr_d;
      wdata     <= wdata_d;
    end
  end

endmodule
